keypad_lock_ctrl: RTL and testbench

Parametrised successor to the single-code keypad lock. It accepts digits strobed by `equals` and compares them against NUM_CODES programmable codes of CODE_LEN digits each. On a match it drives a timed unlock; on a mismatch it counts failures and enters a timed lockout after MAX_FAILS consecutive failures. It sits between the keypad front-end (debounced `digit`/`equals`) and the door actuator/status LEDs.

---
 rtl/keypad_lock_pkg.sv | 24 ++
 rtl/keypad_press_detect.sv | 20 ++
 rtl/keypad_lock_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_lock_pkg.sv
// Shared types and helpers for the keypad lock controller.
// Ports: none (package). Provides the lock state enum and a digit slice helper.
// Code slices handed to digit_at are zero-extended to MAX_CODE_BITS.
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  // Widest single code (CODE_LEN*DIGIT_W) the helper can slice.
  localparam int MAX_CODE_BITS = 256;

  // Returns digit number idx of a packed code, first-entered digit in the LSBs.
  function automatic logic [31:0] digit_at(input logic [MAX_CODE_BITS-1:0] code,
                                           input int idx, input int dw);
    logic [MAX_CODE_BITS-1:0] sh;
    sh = code >> (idx * dw);
    return sh[31:0] & ((32'd1 << dw) - 32'd1);
  endfunction

endpackage

// File: rtl/keypad_press_detect.sv
// Turns the level `equals` strobe into a one-cycle press pulse on its rising edge.
// Ports: clk, reset (async active-high), equals (level in), press (combinational pulse out).
// Holding equals high yields exactly one press; eq_q tracks equals in every state.
module keypad_press_detect (
  input  logic clk,
  input  logic reset,
  input  logic equals,
  output logic press
);

  logic eq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) eq_q <= 1'b0;
    else       eq_q <= equals;
  end

  assign press = equals & ~eq_q;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Multi-code keypad lock: matches CODE_LEN-digit entries against NUM_CODES live codes,
// drives a timed unlock, counts consecutive failures and enforces a timed lockout.
// Ports: clk, reset (async active-high), equals/digit (keypad), codes (code table),
//        door_status_correct/incorrect, locked_out, match_id, digit_count (all registered).
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int CODE_LEN       = 8,
  parameter int DIGIT_W        = 4,
  parameter int NUM_CODES      = 2,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 2000,
  localparam int ID_W   = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1,
  localparam int CNT_W  = $clog2(CODE_LEN + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              equals,
  input  logic [DIGIT_W-1:0]                digit,
  input  logic [NUM_CODES*CODE_LEN*DIGIT_W-1:0] codes,
  output logic                              door_status_correct,
  output logic                              door_status_incorrect,
  output logic                              locked_out,
  output logic [ID_W-1:0]                   match_id,
  output logic [CNT_W-1:0]                  digit_count
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int T_UL   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int T_MAX  = (T_UL > TIMEOUT_CYCLES) ? T_UL : TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX) + 1;

  logic press;

  keypad_press_detect u_press (
    .clk    (clk),
    .reset  (reset),
    .equals (equals),
    .press  (press)
  );

  state_t               state_q, state_d;
  logic [NUM_CODES-1:0] match_vec_q, match_vec_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [FAIL_W-1:0]    fail_q, fail_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 correct_q, correct_d;
  logic                 incorrect_q, incorrect_d;
  logic                 locked_q, locked_d;
  logic [ID_W-1:0]      id_q, id_d;

  // Per-press compare of the incoming digit against every code, at the
  // position this press will occupy (position 0 when starting from IDLE).
  logic [CNT_W-1:0]     cnt_idx;
  logic [CNT_W-1:0]     count_inc;
  logic [NUM_CODES-1:0] digit_hit;
  logic [NUM_CODES-1:0] hit_vec;
  logic                 any_hit;
  logic [ID_W-1:0]      first_id;
  logic [FAIL_W-1:0]    fail_inc;

  always_comb begin
    cnt_idx   = (state_q == IDLE) ? '0 : count_q;
    count_inc = cnt_idx + CNT_W'(1);
    for (int i = 0; i < NUM_CODES; i++) begin
      digit_hit[i] = (digit_at(MAX_CODE_BITS'(codes[i*CODE_W +: CODE_W]), int'(cnt_idx), DIGIT_W)
                      == 32'(digit));
    end
    hit_vec = ((state_q == IDLE) ? {NUM_CODES{1'b1}} : match_vec_q) & digit_hit;
    any_hit = |hit_vec;
    // Scan downward so the lowest matching index is the one that sticks.
    first_id = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      if (hit_vec[i]) first_id = ID_W'(i);
    end
    fail_inc = fail_q + FAIL_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    match_vec_d = match_vec_q;
    count_d     = count_q;
    fail_d      = fail_q;
    timer_d     = timer_q;
    correct_d   = correct_q;
    incorrect_d = 1'b0;
    locked_d    = locked_q;
    id_d        = id_q;

    case (state_q)
      IDLE, ENTRY: begin
        // A press beats a coinciding timeout expiry.
        if (press) begin
          match_vec_d = hit_vec;
          count_d     = count_inc;
          timer_d     = TMR_W'(TIMEOUT_CYCLES);
          state_d     = ENTRY;
          if (count_inc == CNT_W'(CODE_LEN)) begin
            count_d = '0;
            if (any_hit) begin
              id_d      = first_id;
              fail_d    = '0;
              timer_d   = TMR_W'(UNLOCK_CYCLES);
              correct_d = 1'b1;
              state_d   = UNLOCKED;
            end else begin
              incorrect_d = 1'b1;
              fail_d      = fail_inc;
              if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                timer_d  = TMR_W'(LOCKOUT_CYCLES);
                locked_d = 1'b1;
                state_d  = LOCKOUT;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end else if (state_q == ENTRY) begin
          // Timer loaded with N expires on the Nth edge after the load.
          if (timer_q == TMR_W'(1)) begin
            count_d = '0;
            state_d = IDLE;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      UNLOCKED: begin
        if (timer_q == TMR_W'(1)) begin
          correct_d = 1'b0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      LOCKOUT: begin
        if (timer_q == TMR_W'(1)) begin
          locked_d = 1'b0;
          fail_d   = '0;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      match_vec_q <= '0;
      count_q     <= '0;
      fail_q      <= '0;
      timer_q     <= '0;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
      locked_q    <= 1'b0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      match_vec_q <= match_vec_d;
      count_q     <= count_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      correct_q   <= correct_d;
      incorrect_q <= incorrect_d;
      locked_q    <= locked_d;
      id_q        <= id_d;
    end
  end

  assign door_status_correct   = correct_q;
  assign door_status_incorrect = incorrect_q;
  assign locked_out            = locked_q;
  assign match_id              = id_q;
  assign digit_count           = count_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Self-checking bench for keypad_lock_ctrl: scripted scenarios plus random entries,
// every cycle compared against a cycle-count/queue based behavioural model.
// Ports: none (top-level bench).
module tb_keypad_lock_ctrl;

  localparam int CODE_LEN  = 8;
  localparam int DIGIT_W   = 4;
  localparam int NUM_CODES = 2;
  localparam int MAX_FAILS = 3;
  localparam int UNLOCK    = 500;
  localparam int LOCKOUT   = 1000;
  localparam int TIMEOUT   = 2000;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_UNLOCKED = 2, M_LOCKOUT = 3;

  logic                                  clk = 1'b0;
  logic                                  reset;
  logic                                  equals;
  logic [DIGIT_W-1:0]                    digit;
  logic [NUM_CODES*CODE_LEN*DIGIT_W-1:0] codes;
  logic                                  door_status_correct;
  logic                                  door_status_incorrect;
  logic                                  locked_out;
  logic [0:0]                            match_id;
  logic [3:0]                            digit_count;

  keypad_lock_ctrl #(
    .CODE_LEN       (CODE_LEN),
    .DIGIT_W        (DIGIT_W),
    .NUM_CODES      (NUM_CODES),
    .MAX_FAILS      (MAX_FAILS),
    .UNLOCK_CYCLES  (UNLOCK),
    .LOCKOUT_CYCLES (LOCKOUT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .equals                (equals),
    .digit                 (digit),
    .codes                 (codes),
    .door_status_correct   (door_status_correct),
    .door_status_incorrect (door_status_incorrect),
    .locked_out            (locked_out),
    .match_id              (match_id),
    .digit_count           (digit_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Code table in entry order.
  int cd[NUM_CODES][CODE_LEN];

  // Behavioural model: digits entered so far, cycle stamps for deadlines.
  int  m_mode;
  int  q[$];
  int  last_press;
  int  end_cyc;
  int  fails;
  bit  eq_prev;
  bit  e_correct, e_incorrect, e_locked;
  int  e_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; q.delete(); last_press = 0; end_cyc = 0; fails = 0;
    eq_prev = 1'b0; e_correct = 1'b0; e_incorrect = 1'b0; e_locked = 1'b0; e_id = 0;
  endtask

  function automatic int find_match();
    for (int i = 0; i < NUM_CODES; i++) begin
      bit ok = 1'b1;
      for (int j = 0; j < CODE_LEN; j++) if (q[j] != cd[i][j]) ok = 1'b0;
      if (ok) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input bit eq, input int d);
    bit pr;
    int m;
    cyc++;
    pr = eq && !eq_prev;
    eq_prev = eq;
    e_incorrect = 1'b0;
    if (m_mode == M_UNLOCKED) begin
      if (cyc == end_cyc) begin m_mode = M_IDLE; e_correct = 1'b0; end
    end else if (m_mode == M_LOCKOUT) begin
      if (cyc == end_cyc) begin m_mode = M_IDLE; e_locked = 1'b0; fails = 0; end
    end else if (pr) begin
      q.push_back(d);
      last_press = cyc;
      m_mode = M_ENTRY;
      if (q.size() == CODE_LEN) begin
        m = find_match();
        q.delete();
        if (m >= 0) begin
          m_mode = M_UNLOCKED; end_cyc = cyc + UNLOCK;
          e_correct = 1'b1; e_id = m; fails = 0;
        end else begin
          e_incorrect = 1'b1;
          fails++;
          if (fails == MAX_FAILS) begin
            m_mode = M_LOCKOUT; end_cyc = cyc + LOCKOUT; e_locked = 1'b1;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
    end else if (m_mode == M_ENTRY && cyc == last_press + TIMEOUT) begin
      m_mode = M_IDLE;
      q.delete();
    end
  endtask

  // One clock: drive, let the DUT and model take the edge, compare on the falling edge.
  task automatic tick(input logic eq, input int d);
    equals = eq;
    digit  = DIGIT_W'(d);
    @(posedge clk);
    model_step(eq, d);
    @(negedge clk);
    check("correct", 32'(door_status_correct), 32'(e_correct));
    check("incorrect", 32'(door_status_incorrect), 32'(e_incorrect));
    check("locked_out", 32'(locked_out), 32'(e_locked));
    check("digit_count", 32'(digit_count), 32'(q.size()));
    if (e_correct) check("match_id", 32'(match_id), 32'(e_id));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0);
  endtask

  task automatic press_digit(input int d, input int hold, input int gap);
    repeat (hold) tick(1'b1, d);
    repeat (gap) tick(1'b0, d);
  endtask

  task automatic enter(input int ds[CODE_LEN], input int n);
    for (int j = 0; j < n; j++) press_digit(ds[j], 2, 1);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    equals = 1'b0;
    #1;
    check({tag, "_correct"}, 32'(door_status_correct), 32'd0);
    check({tag, "_incorrect"}, 32'(door_status_incorrect), 32'd0);
    check({tag, "_locked"}, 32'(locked_out), 32'd0);
    check({tag, "_match_id"}, 32'(match_id), 32'd0);
    check({tag, "_digit_count"}, 32'(digit_count), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int c0[CODE_LEN];
    int c1[CODE_LEN];
    int bad[CODE_LEN];
    int ds[CODE_LEN];
    c0  = '{3, 9, 0, 0, 8, 1, 2, 1};
    c1  = '{4, 5, 0, 6, 7, 1, 0, 0};
    bad = '{3, 9, 0, 0, 8, 1, 2, 2};
    for (int j = 0; j < CODE_LEN; j++) begin
      cd[0][j] = c0[j];
      cd[1][j] = c1[j];
    end
    codes = '0;
    for (int i = 0; i < NUM_CODES; i++)
      for (int j = 0; j < CODE_LEN; j++)
        codes[(i*CODE_LEN + j)*DIGIT_W +: DIGIT_W] = DIGIT_W'(cd[i][j]);

    reset = 1'b1; equals = 1'b0; digit = '0;
    model_reset();
    #1;
    check("rst_correct", 32'(door_status_correct), 32'd0);
    check("rst_incorrect", 32'(door_status_incorrect), 32'd0);
    check("rst_locked", 32'(locked_out), 32'd0);
    check("rst_match_id", 32'(match_id), 32'd0);
    check("rst_digit_count", 32'(digit_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Code 0 then code 1 unlock.
    enter(c0, CODE_LEN);
    check("unlock0", 32'(door_status_correct), 32'd1);
    check("unlock0_id", 32'(match_id), 32'd0);
    idle(UNLOCK + 10);
    enter(c1, CODE_LEN);
    check("unlock1_id", 32'(match_id), 32'd1);
    idle(UNLOCK + 10);

    // Three wrong codes -> lockout; correct code ignored during lockout.
    enter(bad, CODE_LEN);
    enter(bad, CODE_LEN);
    enter(bad, CODE_LEN);
    check("lockout", 32'(locked_out), 32'd1);
    enter(c0, CODE_LEN);
    check("lockout_ignores", 32'(door_status_correct), 32'd0);
    idle(LOCKOUT);
    enter(c0, CODE_LEN);
    check("after_lockout", 32'(door_status_correct), 32'd1);
    idle(UNLOCK + 10);

    // Partial entry abandoned by timeout.
    enter(c0, 3);
    idle(TIMEOUT);
    check("timeout_count", 32'(digit_count), 32'd0);
    enter(c0, CODE_LEN);
    check("after_timeout", 32'(door_status_correct), 32'd1);
    idle(UNLOCK + 10);

    // Second press lands exactly on the expiry edge.
    tick(1'b1, 3);
    tick(1'b1, 3);
    repeat (TIMEOUT - 2) tick(1'b0, 3);
    tick(1'b1, 9);
    check("expiry_press", 32'(digit_count), 32'd2);
    tick(1'b0, 9);
    for (int j = 2; j < CODE_LEN; j++) press_digit(c0[j], 2, 1);
    check("expiry_unlock", 32'(door_status_correct), 32'd1);
    idle(UNLOCK + 10);

    // Reset mid-entry and during unlock.
    enter(c0, 5);
    do_reset("rst_entry");
    enter(c0, CODE_LEN);
    do_reset("rst_unlock");
    enter(c0, CODE_LEN);
    check("rst_reentry", 32'(door_status_correct), 32'd1);
    idle(UNLOCK + 10);

    // Random entries: correct, corrupted, truncated, with varied holds and gaps.
    for (int it = 0; it < 60; it++) begin
      int sel, n, pos;
      sel = int'($urandom_range(0, 3));
      for (int j = 0; j < CODE_LEN; j++) ds[j] = (sel == 1 || sel == 3) ? c1[j] : c0[j];
      if (sel >= 2) begin
        pos = int'($urandom_range(0, CODE_LEN - 1));
        ds[pos] = (ds[pos] + 1 + int'($urandom_range(0, 14))) % 16;
      end
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, CODE_LEN - 1)) : CODE_LEN;
      for (int j = 0; j < n; j++)
        press_digit(ds[j], int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
      if (n < CODE_LEN) idle(int'($urandom_range(TIMEOUT - 5, TIMEOUT + 3)));
      else if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(400, 1100)));
      else idle(int'($urandom_range(1, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
